// File: rtl/data_memory_unit.sv
// ============================================================================
// data_memory_unit : byte-addressed RV32I data memory, valid/ready request port
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory_unit #(
    parameter int NUM_BYTES     = 64,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic                     request_write,
    input  logic [ADDRESS_WIDTH-1:0] request_address,
    input  logic [2:0]               request_funct3,
    input  logic [31:0]              request_write_data,
    output logic                     response_valid,
    output logic [31:0]              response_read_data,
    output logic                     response_error
);

    localparam int c_num_words = NUM_BYTES / 4;
    localparam int c_idx_w     = $clog2(NUM_BYTES);
    localparam int c_widx_w    = (c_idx_w > 2) ? (c_idx_w - 2) : 1;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [31:0]           r_mem [c_num_words];
    logic [c_widx_w-1:0]   w_widx;
    logic [c_widx_w-1:0]   r_widx;
    logic [1:0]            r_addr_lo;
    logic [2:0]            r_funct3;

    logic                  w_accept;
    logic                  w_out_of_range;
    logic                  w_illegal;
    logic                  w_error;
    logic                  w_store_en;
    logic [3:0]            w_be;
    logic [31:0]           w_lanes;
    logic [31:0]           w_rword;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load_data;

    logic                  r_resp_valid;
    logic [31:0]           r_resp_data;
    logic                  r_resp_error;

    generate
        if (ADDRESS_WIDTH > c_idx_w) begin : g_range
            assign w_out_of_range = |request_address[ADDRESS_WIDTH-1:c_idx_w];
        end else begin : g_no_range
            assign w_out_of_range = 1'b0;
        end
        if (c_idx_w > 2) begin : g_widx
            assign w_widx = request_address[c_idx_w-1:2];
        end else begin : g_single_word
            assign w_widx = '0;
        end
    endgenerate

    assign request_ready = (r_state == S_IDLE);
    assign w_accept      = request_valid & request_ready;
    assign w_store_en    = w_accept & reset_n & request_write & ~w_error;

    // Funct3 legality differs between loads and stores; alignment follows access size.
    always_comb begin
        w_illegal = 1'b0;
        if (request_write) begin
            case (request_funct3)
                c_F3_B:  w_illegal = 1'b0;
                c_F3_H:  w_illegal = request_address[0];
                c_F3_W:  w_illegal = |request_address[1:0];
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (request_funct3)
                c_F3_B, c_F3_BU: w_illegal = 1'b0;
                c_F3_H, c_F3_HU: w_illegal = request_address[0];
                c_F3_W:          w_illegal = |request_address[1:0];
                default:         w_illegal = 1'b1;
            endcase
        end
        w_error = w_illegal | w_out_of_range;
    end

    always_comb begin
        w_be    = 4'b0000;
        w_lanes = request_write_data;
        case (request_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << request_address[1:0];
                w_lanes = {4{request_write_data[7:0]}};
            end
            2'b01: begin
                w_be    = request_address[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{request_write_data[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_lanes = request_write_data;
            end
            default: begin
                w_be    = 4'b0000;
                w_lanes = request_write_data;
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_widx    <= '0;
            r_addr_lo <= 2'b00;
            r_funct3  <= 3'b000;
        end else if (w_accept) begin
            r_widx    <= w_widx;
            r_addr_lo <= request_address[1:0];
            r_funct3  <= request_funct3;
        end
    end

    assign w_rword = r_mem[r_widx];
    assign w_byte  = w_rword[{r_addr_lo, 3'b000} +: 8];
    assign w_half  = r_addr_lo[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load_data = w_rword;
        case (r_funct3)
            c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load_data = {24'h0, w_byte};
            c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load_data = {16'h0, w_half};
            default: w_load_data = w_rword;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (request_write || w_error) ? S_RESPOND : S_ACCESS;
                end
            end
            S_ACCESS:  w_next = S_RESPOND;
            S_RESPOND: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Response registers load on the edge entering RESPOND and clear otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_valid <= (w_next == S_RESPOND);
            r_resp_error <= (r_state == S_IDLE) & w_accept & w_error;
            r_resp_data  <= (r_state == S_ACCESS) ? w_load_data : 32'h0;
        end
    end

    assign response_valid     = r_resp_valid;
    assign response_read_data = r_resp_data;
    assign response_error     = r_resp_error;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
// ============================================================================
// tb_data_memory_unit : scoreboard bench for data_memory_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_unit;

    localparam int NUM_BYTES     = 64;
    localparam int ADDRESS_WIDTH = 32;

    logic                     clock;
    logic                     reset_n;
    logic                     request_valid;
    logic                     request_ready;
    logic                     request_write;
    logic [ADDRESS_WIDTH-1:0] request_address;
    logic [2:0]               request_funct3;
    logic [31:0]              request_write_data;
    logic                     response_valid;
    logic [31:0]              response_read_data;
    logic                     response_error;

    data_memory_unit #(
        .NUM_BYTES     (NUM_BYTES),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .request_valid      (request_valid),
        .request_ready      (request_ready),
        .request_write      (request_write),
        .request_address    (request_address),
        .request_funct3     (request_funct3),
        .request_write_data (request_write_data),
        .response_valid     (response_valid),
        .response_read_data (response_read_data),
        .response_error     (response_error)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_pushed = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset_n && request_valid && request_ready) n_acc <= n_acc + 1;
    end

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response appears.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n) begin
            if (exp_q.size() != 0) check_value("ready_busy", {63'h0, request_ready}, 64'h0);
            if (response_valid) begin
                if (exp_q.size() == 0) begin
                    check_value("spurious_response", 64'h1, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("resp_data", {32'h0, response_read_data}, {32'h0, e.data});
                    check_value("resp_error", {63'h0, response_error}, {63'h0, e.err});
                    check_value("resp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check_value("idle_outputs", {31'h0, response_error, response_read_data}, 64'h0);
            end
        end
    end

    // Called at a negedge; leaves request_valid high and returns at a negedge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wdata, input logic eerr, input logic [31:0] edata);
        int   n;
        exp_t e;
        n                  = 0;
        request_valid      = 1'b1;
        request_write      = wr;
        request_address    = addr;
        request_funct3     = f3;
        request_write_data = wdata;
        while (!request_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (!request_ready) begin
            check_value("accept_timeout", 64'h0, 64'h1);
            request_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            e.err  = eerr;
            e.data = edata;
            e.cyc  = cyc + ((!wr && !eerr) ? 1 : 0);
            exp_q.push_back(e);
            n_pushed++;
            @(negedge clock);
        end
    endtask

    initial begin
        int n;
        reset_n            = 1'b0;
        request_valid      = 1'b0;
        request_write      = 1'b0;
        request_address    = '0;
        request_funct3     = 3'b000;
        request_write_data = 32'h0;

        @(negedge clock);
        check_value("reset_outputs", {31'h0, response_error, response_read_data}, 64'h0);
        check_value("reset_valid", {63'h0, response_valid}, 64'h0);
        check_value("reset_ready", {63'h0, request_ready}, 64'h1);
        reset_n = 1'b1;

        // Basic word store / load
        send(1, 32'h08, 3'b010, 32'hDEADBEEF, 0, 32'h0);
        send(0, 32'h08, 3'b010, 32'h0,        0, 32'hDEADBEEF);

        // Byte store, then sub-word loads with sign/zero extension
        send(1, 32'h09, 3'b000, 32'hFFFFFF5A, 0, 32'h0);
        send(0, 32'h08, 3'b010, 32'h0, 0, 32'hDEAD5AEF);
        send(0, 32'h0B, 3'b000, 32'h0, 0, 32'hFFFFFFDE);
        send(0, 32'h0B, 3'b100, 32'h0, 0, 32'h000000DE);
        send(0, 32'h0A, 3'b001, 32'h0, 0, 32'hFFFFDEAD);
        send(0, 32'h08, 3'b101, 32'h0, 0, 32'h00005AEF);

        // Error cases leave storage untouched
        send(1, 32'h04, 3'b010, 32'hCAFEF00D, 0, 32'h0);
        send(0, 32'h06, 3'b010, 32'h0,        1, 32'h0);
        send(1, 32'h03, 3'b001, 32'h0000FFFF, 1, 32'h0);
        send(0, 32'h40, 3'b000, 32'h0,        1, 32'h0);
        send(1, 32'h04, 3'b100, 32'h12345678, 1, 32'h0);
        send(1, 32'h06, 3'b001, 32'h0000BBBB, 0, 32'h0);
        send(0, 32'h04, 3'b011, 32'h0,        1, 32'h0);
        send(0, 32'h04, 3'b110, 32'h0,        1, 32'h0);
        send(1, 32'h80000004, 3'b010, 32'h0,  1, 32'h0);
        send(0, 32'h04, 3'b010, 32'h0,        0, 32'hBBBBF00D);

        // Top-of-memory boundary
        send(1, 32'h3C, 3'b010, 32'h11223344, 0, 32'h0);
        send(0, 32'h3C, 3'b010, 32'h0, 0, 32'h11223344);
        send(0, 32'h3F, 3'b100, 32'h0, 0, 32'h00000011);
        send(0, 32'h3F, 3'b000, 32'h0, 0, 32'h00000011);
        send(0, 32'h3F, 3'b001, 32'h0, 1, 32'h0);
        send(0, 32'h3D, 3'b010, 32'h0, 1, 32'h0);
        send(0, 32'h3E, 3'b101, 32'h0, 0, 32'h00001122);

        // request_valid held high across alternating stores and loads
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'h10 + 32'(4 * (i % 4));
            d = (32'h01010101 * 32'(i + 1)) ^ 32'hA5C3_0F96;
            send(1, a, 3'b010, d, 0, 32'h0);
            send(0, a, 3'b010, 32'h0, 0, d);
        end

        // Reset asserted while a load is in ACCESS
        send(0, 32'h3C, 3'b010, 32'h0, 0, 32'h11223344);
        #2;
        reset_n       = 1'b0;
        request_valid = 1'b0;
        exp_q.delete();
        n_pushed--;
        #1;
        check_value("midreset_outputs", {31'h0, response_error, response_read_data}, 64'h0);
        check_value("midreset_valid", {63'h0, response_valid}, 64'h0);
        check_value("midreset_ready", {63'h0, request_ready}, 64'h1);
        repeat (2) begin
            @(negedge clock);
            check_value("reset_held_valid", {63'h0, response_valid}, 64'h0);
        end
        reset_n = 1'b1;
        n_acc   = n_acc - 1;
        repeat (2) begin
            @(negedge clock);
            check_value("post_reset_valid", {63'h0, response_valid}, 64'h0);
        end
        send(0, 32'h3C, 3'b010, 32'h0, 0, 32'h11223344);

        // Drain
        request_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_value("drain_left", 64'(exp_q.size()), 64'h0);
        check_value("accept_count", 64'(n_acc), 64'(n_pushed));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
